// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue controller: FSM states, rounding modes,
// exception flag bit positions and opcode encoding.
package fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  // Positions inside the {NV,DZ,OF,UF,NX} flag vector
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [4:0] OP_FADD  = 5'd0;
  localparam logic [4:0] OP_FSUB  = 5'd1;
  localparam logic [4:0] OP_FMUL  = 5'd2;
  localparam logic [4:0] OP_FDIV  = 5'd3;
  localparam logic [4:0] OP_FSQRT = 5'd4;

  function automatic logic [2:0] effective_rm(input logic [2:0] rm, input logic [2:0] frm);
    return (rm == RM_DYN) ? frm : rm;
  endfunction

  function automatic logic rm_legal(input logic [2:0] rm);
    return (rm <= RM_RMM);
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl.sv
// Single-operation FPU issue/writeback controller (IDLE -> ISSUE -> WAIT -> WB).
// Optional sticky exception accumulator enabled by macro FPU_FFLAGS_ACC_EN.
module fpu_issue_ctrl
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [2:0]  req_rm,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  input  logic [2:0]  frm,
  output logic        fpu_valid_out,
  input  logic        fpu_ready_in,
  output logic [4:0]  fpu_op,
  output logic [2:0]  fpu_rm,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic        fpu_valid_in,
  output logic        fpu_ready_out,
  input  logic [31:0] fpu_y,
  input  logic        fpu_IV,
  input  logic        fpu_DZ,
  input  logic        fpu_OF,
  input  logic        fpu_UF,
  input  logic        fpu_IE,
  output logic        fpu_flush,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic [4:0]  wb_flags,
`ifdef FPU_FFLAGS_ACC_EN
  input  logic        fflags_clr,
  output logic [4:0]  fflags_out,
`endif
  output logic        illegal_rm
);

  state_e      state;
  state_e      state_next;
  logic [2:0]  rm_eff;
  logic        rm_ok;
  logic        accept;
  logic        issue_done;
  logic        result_done;
  logic        wb_done;
  logic [4:0]  res_flags;

  always_comb begin
    rm_eff      = effective_rm(req_rm, frm);
    rm_ok       = rm_legal(rm_eff);
    // flush blocks every handshake in the cycle it is asserted
    accept      = (state == ST_IDLE)  && req_valid    && !flush;
    issue_done  = (state == ST_ISSUE) && fpu_ready_in && !flush;
    result_done = (state == ST_WAIT)  && fpu_valid_in && !flush;
    wb_done     = (state == ST_WB)    && wb_ready     && !flush;
    res_flags          = 5'd0;
    res_flags[FLAG_NV] = fpu_IV;
    res_flags[FLAG_DZ] = fpu_DZ;
    res_flags[FLAG_OF] = fpu_OF;
    res_flags[FLAG_UF] = fpu_UF;
    res_flags[FLAG_NX] = fpu_IE;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_next = (accept && rm_ok) ? ST_ISSUE : ST_IDLE;
        ST_ISSUE: state_next = issue_done  ? ST_WAIT : ST_ISSUE;
        ST_WAIT:  state_next = result_done ? ST_WB   : ST_WAIT;
        ST_WB:    state_next = wb_done     ? ST_IDLE : ST_WB;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_rm <= 1'b0;
      fpu_op     <= 5'd0;
      fpu_rm     <= 3'd0;
      fpu_a      <= 32'd0;
      fpu_b      <= 32'd0;
      wb_rd      <= 5'd0;
      wb_data    <= 32'd0;
      wb_flags   <= 5'd0;
    end else begin
      illegal_rm <= accept && !rm_ok;
      if (accept && rm_ok) begin
        fpu_op <= req_op;
        fpu_rm <= rm_eff;
        fpu_a  <= req_a;
        fpu_b  <= req_b;
        wb_rd  <= req_rd;
      end
      if (result_done) begin
        wb_data  <= fpu_y;
        wb_flags <= res_flags;
      end
    end
  end

`ifdef FPU_FFLAGS_ACC_EN
  // Sticky accumulator: a clear removes older bits but never this cycle's new flags
  always_ff @(posedge clk) begin
    if (reset)           fflags_out <= 5'd0;
    else if (wb_done)    fflags_out <= (fflags_clr ? 5'd0 : fflags_out) | wb_flags;
    else if (fflags_clr) fflags_out <= 5'd0;
    else                 fflags_out <= fflags_out;
  end
`endif

  assign req_ready     = (state == ST_IDLE) && !flush && !reset;
  assign fpu_valid_out = (state == ST_ISSUE);
  assign fpu_ready_out = (state == ST_WAIT);
  assign wb_valid      = (state == ST_WB);
  assign fpu_flush     = flush;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset, flush, req_valid, req_ready;
  logic [4:0]  req_op, req_rd;
  logic [2:0]  req_rm, frm;
  logic [31:0] req_a, req_b;
  logic        fpu_valid_out, fpu_ready_in, fpu_valid_in, fpu_ready_out;
  logic [4:0]  fpu_op;
  logic [2:0]  fpu_rm;
  logic [31:0] fpu_a, fpu_b, fpu_y;
  logic        fpu_IV, fpu_DZ, fpu_OF, fpu_UF, fpu_IE, fpu_flush;
  logic        wb_valid, wb_ready, illegal_rm;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd, wb_flags;
`ifdef FPU_FFLAGS_ACC_EN
  logic        fflags_clr;
  logic [4:0]  fflags_out;
  logic [4:0]  acc_model;
`endif

  int vectors = 0;
  int miscompares = 0;

  fpu_issue_ctrl dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .frm(frm),
    .fpu_valid_out(fpu_valid_out), .fpu_ready_in(fpu_ready_in),
    .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_valid_in(fpu_valid_in), .fpu_ready_out(fpu_ready_out), .fpu_y(fpu_y),
    .fpu_IV(fpu_IV), .fpu_DZ(fpu_DZ), .fpu_OF(fpu_OF), .fpu_UF(fpu_UF), .fpu_IE(fpu_IE),
    .fpu_flush(fpu_flush), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_flags(wb_flags),
`ifdef FPU_FFLAGS_ACC_EN
    .fflags_clr(fflags_clr), .fflags_out(fflags_out),
`endif
    .illegal_rm(illegal_rm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [4:0] f);
    {fpu_IV, fpu_DZ, fpu_OF, fpu_UF, fpu_IE} = f;
  endtask

  task automatic drive_req(input logic [4:0] op, input logic [2:0] rm, input logic [2:0] fr,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    req_valid = 1'b1; req_op = op; req_rm = rm; frm = fr; req_a = a; req_b = b; req_rd = rd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; fpu_ready_in = 1'b0; fpu_valid_in = 1'b0;
    wb_ready = 1'b0; req_op = 5'd0; req_rm = 3'd0; frm = 3'd0; req_a = 32'd0; req_b = 32'd0;
    req_rd = 5'd0; fpu_y = 32'd0; set_flags(5'd0);
`ifdef FPU_FFLAGS_ACC_EN
    fflags_clr = 1'b0; acc_model = 5'd0;
`endif
    tick(); tick();
    vectors++;
    if ({req_ready, fpu_valid_out, fpu_ready_out, wb_valid, illegal_rm} !== 5'b0) begin
      miscompares++; $display("FAIL reset_handshakes: got %b want 00000",
        {req_ready, fpu_valid_out, fpu_ready_out, wb_valid, illegal_rm});
    end
    vectors++;
    if ({wb_data, wb_rd, wb_flags} !== 42'd0) begin
      miscompares++; $display("FAIL reset_wb: got %h/%h/%h want 0", wb_data, wb_rd, wb_flags);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_idle_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_fadd();
    drive_req(5'd0, 3'b000, 3'b011, 32'h3F800000, 32'h40000000, 5'd5);
    vectors++;
    if ({fpu_valid_out, fpu_op, fpu_rm, fpu_a, fpu_b} !== {1'b1, 5'd0, 3'b000, 32'h3F800000, 32'h40000000}) begin
      miscompares++; $display("FAIL fadd_issue: got v=%b op=%h rm=%b a=%h b=%h want v=1 op=0 rm=000 a=3f800000 b=40000000",
        fpu_valid_out, fpu_op, fpu_rm, fpu_a, fpu_b);
    end
    fpu_ready_in = 1'b1; tick(); fpu_ready_in = 1'b0;
    fpu_valid_in = 1'b1; fpu_y = 32'h40400000; set_flags(5'd0); tick(); fpu_valid_in = 1'b0;
    vectors++;
    if ({wb_valid, wb_data, wb_rd, wb_flags} !== {1'b1, 32'h40400000, 5'd5, 5'd0}) begin
      miscompares++; $display("FAIL fadd_wb: got v=%b d=%h rd=%0d f=%b want v=1 d=40400000 rd=5 f=00000",
        wb_valid, wb_data, wb_rd, wb_flags);
    end
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;
    vectors++;
    if ({wb_valid, req_ready} !== 2'b01) begin
      miscompares++; $display("FAIL fadd_return_idle: got wb_valid=%b req_ready=%b want 0/1", wb_valid, req_ready);
    end
  endtask

  task automatic test_illegal_rm();
    drive_req(5'd2, 3'b111, 3'b101, 32'h1, 32'h2, 5'd7);
    vectors++;
    if ({illegal_rm, fpu_valid_out, req_ready} !== 3'b101) begin
      miscompares++; $display("FAIL illegal_pulse: got ill=%b fvo=%b rdy=%b want 1/0/1", illegal_rm, fpu_valid_out, req_ready);
    end
    tick();
    vectors++;
    if ({illegal_rm, fpu_valid_out} !== 2'b00) begin
      miscompares++; $display("FAIL illegal_once: got ill=%b fvo=%b want 0/0", illegal_rm, fpu_valid_out);
    end
  endtask

  task automatic test_fdiv_dz();
    drive_req(5'd3, 3'b000, 3'b000, 32'h3F800000, 32'h00000000, 5'd9);
    fpu_ready_in = 1'b1; tick(); fpu_ready_in = 1'b0;
    tick();
    fpu_valid_in = 1'b1; fpu_y = 32'h7F800000; set_flags(5'b01000); tick(); fpu_valid_in = 1'b0;
    set_flags(5'd0);
    vectors++;
    if ({wb_valid, wb_flags, wb_rd} !== {1'b1, 5'b01000, 5'd9}) begin
      miscompares++; $display("FAIL fdiv_flags: got v=%b f=%b rd=%0d want 1/01000/9", wb_valid, wb_flags, wb_rd);
    end
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;
`ifdef FPU_FFLAGS_ACC_EN
    acc_model = acc_model | 5'b01000;
    tick(); tick();
    vectors++;
    if (fflags_out !== acc_model) begin
      miscompares++; $display("FAIL fflags_sticky: got %b want %b", fflags_out, acc_model);
    end
    fflags_clr = 1'b1; tick(); fflags_clr = 1'b0;
    acc_model = 5'd0;
    vectors++;
    if (fflags_out !== acc_model) begin
      miscompares++; $display("FAIL fflags_clear: got %b want %b", fflags_out, acc_model);
    end
`endif
  endtask

  task automatic test_wb_stall();
    drive_req(5'd2, 3'b010, 3'b000, 32'hDEADBEEF, 32'h12345678, 5'd17);
    fpu_ready_in = 1'b1; tick(); fpu_ready_in = 1'b0;
    fpu_valid_in = 1'b1; fpu_y = 32'hCAFEF00D; set_flags(5'b00001); tick(); fpu_valid_in = 1'b0;
    fpu_y = 32'h0; set_flags(5'd0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({wb_valid, wb_data, wb_rd, wb_flags, req_ready} !== {1'b1, 32'hCAFEF00D, 5'd17, 5'b00001, 1'b0}) begin
        miscompares++; $display("FAIL wb_stall_%0d: got v=%b d=%h rd=%0d f=%b rdy=%b want 1/cafef00d/17/00001/0",
          i, wb_valid, wb_data, wb_rd, wb_flags, req_ready);
      end
      tick();
    end
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;
`ifdef FPU_FFLAGS_ACC_EN
    acc_model = acc_model | 5'b00001;
`endif
  endtask

  task automatic test_flush();
    drive_req(5'd1, 3'b001, 3'b000, 32'h5, 32'h6, 5'd3);
    fpu_ready_in = 1'b1; tick(); fpu_ready_in = 1'b0;
    flush = 1'b1; #1;
    vectors++;
    if (fpu_flush !== 1'b1) begin
      miscompares++; $display("FAIL flush_forward: got %b want 1", fpu_flush);
    end
    tick(); flush = 1'b0; #1;
    vectors++;
    if ({req_ready, fpu_ready_out, wb_valid} !== 3'b100) begin
      miscompares++; $display("FAIL flush_idle: got rdy=%b fro=%b wbv=%b want 1/0/0", req_ready, fpu_ready_out, wb_valid);
    end
    fpu_valid_in = 1'b1; fpu_y = 32'hBAD0BAD0; tick(); fpu_valid_in = 1'b0;
    vectors++;
    if ({wb_valid, fpu_valid_out} !== 2'b00) begin
      miscompares++; $display("FAIL flush_late_result: got wbv=%b fvo=%b want 0/0", wb_valid, fpu_valid_out);
    end
    flush = 1'b1;
    drive_req(5'd0, 3'b000, 3'b000, 32'h1, 32'h1, 5'd1);
    flush = 1'b0; #1;
    vectors++;
    if ({fpu_valid_out, req_ready} !== 2'b01) begin
      miscompares++; $display("FAIL flush_blocks_req: got fvo=%b rdy=%b want 0/1", fpu_valid_out, req_ready);
    end
  endtask

  task automatic test_reset_in_issue();
    drive_req(5'd4, 3'b100, 3'b000, 32'h77, 32'h88, 5'd30);
    reset = 1'b1; tick();
    vectors++;
    if ({req_ready, fpu_valid_out, fpu_ready_out, wb_valid, illegal_rm, wb_data, wb_rd, wb_flags} !== 47'd0) begin
      miscompares++; $display("FAIL reset_issue_outputs: got rdy=%b fvo=%b fro=%b wbv=%b ill=%b d=%h rd=%h f=%b want all 0",
        req_ready, fpu_valid_out, fpu_ready_out, wb_valid, illegal_rm, wb_data, wb_rd, wb_flags);
    end
`ifdef FPU_FFLAGS_ACC_EN
    acc_model = 5'd0;
    vectors++;
    if (fflags_out !== 5'd0) begin
      miscompares++; $display("FAIL reset_issue_fflags: got %b want 0", fflags_out);
    end
`endif
    reset = 1'b0;
    test_fadd();
  endtask

  // Randomized transactions; the model predicts each step from the handshake rules.
  task automatic test_random(input int n);
    logic [4:0]  op, rd, fl;
    logic [2:0]  rm, fr, eff;
    logic [31:0] a, b, y;
    int          d;
    for (int t = 0; t < n; t++) begin
      op = 5'($urandom_range(0, 4)); rm = 3'($urandom); fr = 3'($urandom);
      a = $urandom; b = $urandom; rd = 5'($urandom); y = $urandom; fl = 5'($urandom);
      eff = (rm == 3'b111) ? fr : rm;
      drive_req(op, rm, fr, a, b, rd);
      if (eff > 3'd4) begin
        vectors++;
        if ({illegal_rm, fpu_valid_out, req_ready} !== 3'b101) begin
          miscompares++; $display("FAIL rand_illegal_%0d: got ill=%b fvo=%b rdy=%b rm=%b frm=%b want 1/0/1",
            t, illegal_rm, fpu_valid_out, req_ready, rm, fr);
        end
        tick();
        continue;
      end
      d = $urandom_range(0, 3);
      for (int i = 0; i <= d; i++) begin
        vectors++;
        if ({fpu_valid_out, req_ready, illegal_rm, fpu_op, fpu_rm, fpu_a, fpu_b} !== {1'b1, 1'b0, 1'b0, op, eff, a, b}) begin
          miscompares++; $display("FAIL rand_issue_%0d: got v=%b rdy=%b op=%h rm=%b a=%h b=%h want 1/0 op=%h rm=%b a=%h b=%h",
            t, fpu_valid_out, req_ready, fpu_op, fpu_rm, fpu_a, fpu_b, op, eff, a, b);
        end
        if (i == d) fpu_ready_in = 1'b1;
        tick();
      end
      fpu_ready_in = 1'b0;
      d = $urandom_range(0, 3);
      for (int i = 0; i <= d; i++) begin
        vectors++;
        if ({fpu_ready_out, fpu_valid_out, wb_valid} !== 3'b100) begin
          miscompares++; $display("FAIL rand_wait_%0d: got fro=%b fvo=%b wbv=%b want 1/0/0",
            t, fpu_ready_out, fpu_valid_out, wb_valid);
        end
        if (i == d) begin fpu_valid_in = 1'b1; fpu_y = y; set_flags(fl); end
        tick();
      end
      fpu_valid_in = 1'b0; fpu_y = ~y; set_flags(~fl);
      d = $urandom_range(0, 3);
      for (int i = 0; i <= d; i++) begin
        vectors++;
        if ({wb_valid, fpu_ready_out, wb_data, wb_rd, wb_flags} !== {1'b1, 1'b0, y, rd, fl}) begin
          miscompares++; $display("FAIL rand_wb_%0d: got v=%b fro=%b d=%h rd=%0d f=%b want 1/0 d=%h rd=%0d f=%b",
            t, wb_valid, fpu_ready_out, wb_data, wb_rd, wb_flags, y, rd, fl);
        end
        if (i == d) wb_ready = 1'b1;
        tick();
      end
      wb_ready = 1'b0;
`ifdef FPU_FFLAGS_ACC_EN
      acc_model = acc_model | fl;
      vectors++;
      if (fflags_out !== acc_model) begin
        miscompares++; $display("FAIL rand_fflags_%0d: got %b want %b", t, fflags_out, acc_model);
      end
`endif
      vectors++;
      if ({wb_valid, req_ready} !== 2'b01) begin
        miscompares++; $display("FAIL rand_idle_%0d: got wbv=%b rdy=%b want 0/1", t, wb_valid, req_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_illegal_rm();
    test_fdiv_dz();
    test_wb_stall();
    test_flush();
    test_reset_in_issue();
    test_random(60);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
